// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arbiter
// Description : Round-robin front end sharing one combinational ALU between
//               two valid/ready requesters; optional illegal-opcode trap
//               enabled by defining ALU_OPCHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_op1,
    input  logic [2*DATA_W-1:0] req_op2,
    input  logic [2*OP_W-1:0]   req_aluop,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_zero,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   alu_op1,
    output logic [DATA_W-1:0]   alu_op2,
    output logic [OP_W-1:0]     alu_opcode,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    output logic                busy,
    output logic                grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
    logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
    logic [OP_W-1:0]     alu_opc_q, alu_opc_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_zero_q, rsp_zero_d;

    logic                w_accept;
    logic                w_winner;
    logic [DATA_W-1:0]   w_sel_op1;
    logic [DATA_W-1:0]   w_sel_op2;
    logic [OP_W-1:0]     w_sel_opc;

`ifdef ALU_OPCHECK_EN
    localparam logic [OP_W-1:0] c_OP_AND = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] c_OP_OR  = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] c_OP_ADD = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] c_OP_SUB = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] c_OP_SLT = OP_W'(4'b0100);
    localparam logic [OP_W-1:0] c_OP_XOR = OP_W'(4'b0101);
    localparam logic [OP_W-1:0] c_OP_SRL = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] c_OP_SLL = OP_W'(4'b1001);
    localparam logic [OP_W-1:0] c_OP_SRA = OP_W'(4'b1010);

    logic illegal_q, illegal_d;
    logic rsp_err_q, rsp_err_d;

    function automatic logic f_op_legal(input logic [OP_W-1:0] op);
        case (op)
            c_OP_AND, c_OP_OR, c_OP_ADD, c_OP_SUB, c_OP_SLT,
            c_OP_XOR, c_OP_SRL, c_OP_SLL, c_OP_SRA: f_op_legal = 1'b1;
            default:                                f_op_legal = 1'b0;
        endcase
    endfunction
`endif

    // Contention goes to the requester that was not served last.
    always_comb begin
        w_winner  = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        w_accept  = (state_q == ST_IDLE) && (req_valid != 2'b00);
        req_ready = {w_accept & w_winner, w_accept & ~w_winner};
        w_sel_op1 = w_winner ? req_op1[2*DATA_W-1:DATA_W] : req_op1[DATA_W-1:0];
        w_sel_op2 = w_winner ? req_op2[2*DATA_W-1:DATA_W] : req_op2[DATA_W-1:0];
        w_sel_opc = w_winner ? req_aluop[2*OP_W-1:OP_W]   : req_aluop[OP_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_opc_d    = alu_opc_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
`ifdef ALU_OPCHECK_EN
        illegal_d    = illegal_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    grant_d      = w_winner;
                    last_grant_d = w_winner;
                    state_d      = ST_EXEC;
`ifdef ALU_OPCHECK_EN
                    illegal_d    = ~f_op_legal(w_sel_opc);
                    // Illegal opcodes leave the ALU inputs untouched.
                    if (f_op_legal(w_sel_opc)) begin
                        alu_op1_d = w_sel_op1;
                        alu_op2_d = w_sel_op2;
                        alu_opc_d = w_sel_opc;
                    end
`else
                    alu_op1_d    = w_sel_op1;
                    alu_op2_d    = w_sel_op2;
                    alu_opc_d    = w_sel_opc;
`endif
                end
            end
            ST_EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
`ifdef ALU_OPCHECK_EN
                rsp_err_d    = illegal_q;
                if (illegal_q) begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b1;
                end
`endif
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_opc_q    <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_opc_q    <= alu_opc_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

`ifdef ALU_OPCHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid  = (state_q == ST_RESP) ? {grant_q, ~grant_q} : 2'b00;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_opcode = alu_opc_q;
    assign busy       = (state_q != ST_IDLE);
    assign grant_id   = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_arbiter
// Description : Self-checking bench for alu_rr_arbiter with a transaction
//               level reference model and a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_op1, req_op2;
    logic [7:0]  req_aluop;
    logic [31:0] rsp_result, alu_op1, alu_op2, alu_result;
    logic        rsp_zero, rsp_err, alu_zero, busy, grant_id;
    logic [3:0]  alu_opcode;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.DATA_W(32), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_aluop(req_aluop),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .grant_id(grant_id)
    );

    function automatic logic [31:0] f_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: return a ^ b;
            4'b1000: return a >> b[4:0];
            4'b1001: return a << b[4:0];
            4'b1010: return sa >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit f_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100,
                          4'b0101, 4'b1000, 4'b1001, 4'b1010};
    endfunction

`ifdef ALU_OPCHECK_EN
    localparam bit c_OPCHECK = 1'b1;
`else
    localparam bit c_OPCHECK = 1'b0;
`endif

    // External ALU seen by the DUT.
    assign alu_result = f_alu(alu_opcode, alu_op1, alu_op2);
    assign alu_zero   = (alu_result == 32'd0);

    // Requester side stimulus.
    logic [1:0]  vld;
    logic [31:0] o1 [2];
    logic [31:0] o2 [2];
    logic [3:0]  op [2];
    logic [3:0]  legal_tab [9] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};

    assign req_valid = vld;
    assign req_op1   = {o1[1], o1[0]};
    assign req_op2   = {o2[1], o2[0]};
    assign req_aluop = {op[1], op[0]};

    // Reference model: one outstanding operation with its expected response.
    bit          m_busy;
    bit          m_last;
    bit          m_id;
    int          m_acc;
    logic [31:0] m_res;
    bit          m_zero, m_err;
    int          cyc;

    // Values sampled by the most recent step.
    logic [1:0]  s_ready, s_rv;
    logic [31:0] s_res, s_aop1, s_aop2;
    logic [3:0]  s_aopc;
    logic        s_zero, s_err, s_gid, s_busy;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic [1:0] e_ready, e_rv;
        bit         win, acc, rdone;
        @(negedge clk);
        s_ready = req_ready;  s_rv = rsp_valid;  s_res = rsp_result;
        s_zero  = rsp_zero;   s_err = rsp_err;   s_gid = grant_id;
        s_busy  = busy;       s_aop1 = alu_op1;  s_aop2 = alu_op2;
        s_aopc  = alu_opcode;
        win     = (vld == 2'b11) ? !m_last : vld[1];
        e_ready = (m_busy || vld == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
        e_rv    = (m_busy && cyc >= m_acc + 2) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
        acc     = 1'b0;
        rdone   = 1'b0;
        if (!rst) begin
            chk("req_ready", s_ready, e_ready);
            chk("busy", s_busy, m_busy);
            chk("rsp_valid", s_rv, e_rv);
            if (e_rv != 2'b00) begin
                chk("rsp_result", s_res, m_res);
                chk("rsp_zero", s_zero, m_zero);
                chk("rsp_err", s_err, m_err);
                chk("grant_id", s_gid, m_id);
            end
            acc   = (e_ready != 2'b00);
            rdone = (e_rv != 2'b00) && rsp_ready[m_id];
        end
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else begin
            if (rdone) m_busy = 1'b0;
            if (acc) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_id   = win;
                m_last = win;
                if (c_OPCHECK && !f_legal(op[win])) begin
                    m_res = 32'd0;
                    m_err = 1'b1;
                end else begin
                    m_res = f_alu(op[win], o1[win], o2[win]);
                    m_err = 1'b0;
                end
                m_zero = (m_res == 32'd0);
            end
        end
        #1;
        cyc++;
        if (acc) vld[win] = 1'b0;
    endtask

    task automatic new_req(input int i);
        int k;
        k = $urandom_range(0, 11);
        op[i] = (k < 9) ? legal_tab[k] : ((k == 9) ? 4'hF : 4'h3);
        o1[i] = $urandom;
        o2[i] = ($urandom_range(0, 3) == 0) ? o1[i] : $urandom;
        vld[i] = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] p1, p2;
        logic [3:0]  pc;
        rst = 1'b1;  vld = 2'b00;  rsp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            o1[i] = '0;  o2[i] = '0;  op[i] = '0;
        end
        m_busy = 0;  m_last = 1;  m_id = 0;  m_acc = 0;
        m_res = 0;   m_zero = 0;  m_err = 0;  cyc = 0;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;

        // 1: reset values while idle
        step();
        chk("t1_ready", s_ready, 2'b00);
        chk("t1_busy", s_busy, 1'b0);
        chk("t1_rsp_valid", s_rv, 2'b00);
        chk("t1_result", s_res, 32'd0);
        chk("t1_zero", s_zero, 1'b0);
        chk("t1_err", s_err, 1'b0);
        chk("t1_alu_op1", s_aop1, 32'd0);
        chk("t1_alu_op2", s_aop2, 32'd0);
        chk("t1_alu_opcode", s_aopc, 4'd0);
        chk("t1_grant", s_gid, 1'b0);

        // 2: single requester ADD 5+7
        o1[0] = 5;  o2[0] = 7;  op[0] = 4'h2;  vld = 2'b01;  rsp_ready = 2'b11;
        step();  chk("t2_ready", s_ready, 2'b01);
        step();  chk("t2_no_rsp_early", s_rv, 2'b00);
        step();
        chk("t2_rsp_valid", s_rv, 2'b01);
        chk("t2_result", s_res, 32'd12);
        chk("t2_zero", s_zero, 1'b0);

        // 3: contention right after reset, requester 0 first
        rst = 1'b1;  step();  rst = 1'b0;
        o1[0] = 3;            o2[0] = 3;  op[0] = 4'h6;
        o1[1] = 32'hFFFFFFFF; o2[1] = 1;  op[1] = 4'h4;
        vld = 2'b11;
        step();  chk("t3_ready0", s_ready, 2'b01);
        step();
        step();
        chk("t3_result0", s_res, 32'd0);
        chk("t3_zero0", s_zero, 1'b1);
        chk("t3_grant0", s_gid, 1'b0);
        step();  chk("t3_ready1", s_ready, 2'b10);
        step();
        step();
        chk("t3_result1", s_res, 32'd1);
        chk("t3_grant1", s_gid, 1'b1);

        // 4: response backpressure
        o1[0] = 1;  o2[0] = 2;  op[0] = 4'h2;  vld = 2'b01;  rsp_ready = 2'b00;
        step();
        step();
        o1[1] = 32'hF0F0;  o2[1] = 32'h0FF0;  op[1] = 4'h0;  vld[1] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t4_rsp_valid", s_rv, 2'b01);
            chk("t4_result", s_res, 32'd3);
            chk("t4_ready", s_ready, 2'b00);
            chk("t4_busy", s_busy, 1'b1);
        end
        rsp_ready = 2'b11;
        repeat (5) step();

        // 5: reset during EXEC discards the operation
        o1[0] = 9;  o2[0] = 9;  op[0] = 4'h2;  vld = 2'b01;
        step();
        rst = 1'b1;  step();  rst = 1'b0;
        o1[0] = 4;  o2[0] = 1;  op[0] = 4'h9;
        o1[1] = 8;  o2[1] = 2;  op[1] = 4'h8;
        vld = 2'b11;
        step();
        chk("t5_ready", s_ready, 2'b01);
        chk("t5_no_rsp", s_rv, 2'b00);
        repeat (6) step();

        // 6: illegal opcode
        o1[0] = 32'h1234;  o2[0] = 32'h00FF;  op[0] = 4'h5;  vld = 2'b01;
        repeat (3) step();
        p1 = s_aop1;  p2 = s_aop2;  pc = s_aopc;
        o1[0] = 32'hDEAD;  o2[0] = 32'hBEEF;  op[0] = 4'hF;  vld = 2'b01;
        step();
        step();
        step();
        chk("t6_result", s_res, 32'd0);
        chk("t6_zero", s_zero, 1'b1);
        chk("t6_err", s_err, c_OPCHECK);
        chk("t6_alu_opcode", s_aopc, c_OPCHECK ? pc : 4'hF);
        chk("t6_alu_op1", s_aop1, c_OPCHECK ? p1 : 32'hDEAD);
        chk("t6_alu_op2", s_aop2, c_OPCHECK ? p2 : 32'hBEEF);

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!vld[i] && $urandom_range(0, 2) == 0) new_req(i);
            end
            rsp_ready = 2'($urandom);
            step();
        end
        rst = 1'b0;
        vld = 2'b00;
        rsp_ready = 2'b11;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
